// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the requesters, the register-file write arbiter and the read-forward consumers.
// Includes the arbiter's round-robin pointer as a debug observation signal.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  reg_wr_en;
  logic [AW-1:0]         WA;
  logic [DW-1:0]         WData;
  logic [AW-1:0]         rd_addr1;
  logic [AW-1:0]         rd_addr2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [DW-1:0]         fwd_data;
  logic                  x0_drop;
  logic [PW-1:0]         dbg_rr_ptr;

  modport master (
    output req_valid, req_addr, req_data, rd_addr1, rd_addr2,
    input  req_ready, reg_wr_en, WA, WData, fwd1_hit, fwd2_hit, fwd_data, x0_drop, dbg_rr_ptr
  );

  modport slave (
    input  req_valid, req_addr, req_data, rd_addr1, rd_addr2,
    output req_ready, reg_wr_en, WA, WData, fwd1_hit, fwd2_hit, fwd_data, x0_drop, dbg_rr_ptr
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered output stage
// and read-forwarding. Define REGFILE_WR_DBG_PRIO_EN to give requester NUM_REQ-1 absolute priority.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      cand;
  logic               found;
  logic               xfer;
  logic [AW-1:0]      gnt_addr;
  logic [DW-1:0]      gnt_data;

  logic               wr_en_q;
  logic               x0_drop_q;
  logic [AW-1:0]      wa_q;
  logic [DW-1:0]      wd_q;

  // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i].
  // req_ready is combinational and one-hot (or zero); an ungranted requester must
  // keep valid/addr/data stable and is served in a later cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
`ifdef REGFILE_WR_DBG_PRIO_EN
    if (bus.req_valid[NUM_REQ-1]) begin
      found     = 1'b1;
      grant_idx = PW'(NUM_REQ - 1);
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found && !rst) grant[grant_idx] = 1'b1;
  end

  assign xfer     = |grant;
  assign gnt_addr = bus.req_addr[grant_idx*AW +: AW];
  assign gnt_data = bus.req_data[grant_idx*DW +: DW];

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (xfer) begin
`ifdef REGFILE_WR_DBG_PRIO_EN
      // Debug grants bypass the rotation, so the pointer stays put for them.
      if (grant_idx != PW'(NUM_REQ - 1)) rr_ptr_nxt = grant_idx + 1'b1;
`else
      rr_ptr_nxt = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      wr_en_q   <= 1'b0;
      x0_drop_q <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (xfer) begin
        wa_q      <= gnt_addr;
        wd_q      <= gnt_data;
        wr_en_q   <= (gnt_addr != '0);
        x0_drop_q <= (gnt_addr == '0);
      end else begin
        wr_en_q   <= 1'b0;
        x0_drop_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.reg_wr_en  = wr_en_q;
  assign bus.WA         = wa_q;
  assign bus.WData      = wd_q;
  assign bus.x0_drop    = x0_drop_q;
  assign bus.dbg_rr_ptr = rr_ptr;

  // x0 is hardwired to zero, so a read of address 0 must never pick up pending data.
  assign bus.fwd1_hit = wr_en_q & (wa_q == bus.rd_addr1) & (bus.rd_addr1 != '0);
  assign bus.fwd2_hit = wr_en_q & (wa_q == bus.rd_addr2) & (bus.rd_addr2 != '0);
  assign bus.fwd_data = wd_q;
endmodule
